// File: rtl/conv1_pkg.sv
// Shared constants, state encoding and output beat type for the conv1 scheduler.
package conv1_pkg;
  localparam int FILTER_SIZE   = 5;
  localparam int TAPS          = FILTER_SIZE * FILTER_SIZE;
  localparam int CHANNEL_LEN   = 3;
  localparam int OUT_BITS      = 12;
  localparam int ACC_BITS      = 20;
  localparam int CFG_ADDR_BITS = 7;
  localparam int CFG_BIAS_BASE = 75;
  localparam int CFG_ADDR_MAX  = 77;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_e;

  typedef struct packed {
    logic                last;
    logic [1:0]          ch;
    logic [OUT_BITS-1:0] data;
  } out_beat_t;
endpackage

// File: rtl/conv1_sched_if.sv
// Window input, result output and config bus of the conv1 scheduler.
interface conv1_sched_if
  import conv1_pkg::*;
#(
  parameter int DATA_BITS = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [TAPS*DATA_BITS-1:0] win_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [OUT_BITS-1:0]       out_data;
  logic [1:0]                out_ch;
  logic                      out_last;
  logic                      frame_done;
  logic                      cfg_we;
  logic [CFG_ADDR_BITS-1:0]  cfg_addr;
  logic [DATA_BITS-1:0]      cfg_data;
  logic                      cfg_busy;

  modport master (
    output in_valid, win_data, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, out_ch, out_last, frame_done, cfg_busy
  );

  modport slave (
    input  in_valid, win_data, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, out_ch, out_last, frame_done, cfg_busy
  );
endinterface

// File: rtl/conv1_dot25.sv
// Combinational 25-tap MAC: unsigned pixels times signed weights, scaled by 2^-8, plus bias.
module conv1_dot25
  import conv1_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic [TAPS-1:0][DATA_BITS-1:0] win,
  input  logic [TAPS-1:0][DATA_BITS-1:0] wgt,
  input  logic [DATA_BITS-1:0]           bias,
  output logic [OUT_BITS-1:0]            res
);
  logic signed [ACC_BITS-1:0] prod [TAPS];
  logic signed [ACC_BITS-1:0] acc;

  // Pixel gets a zero sign bit so it stays positive in the signed product.
  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    assign prod[i] = ACC_BITS'($signed({1'b0, win[i]})) * ACC_BITS'($signed(wgt[i]));
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < TAPS; i++) acc = acc + prod[i];
  end

  assign res = acc[ACC_BITS-1 -: OUT_BITS] + OUT_BITS'($signed(bias));
endmodule

// File: rtl/conv1_sched.sv
// Conv1 scheduler: captures a 5x5 window, runs 3 channels through one shared MAC,
// streams one channel per beat and counts windows per frame.
module conv1_sched
  import conv1_pkg::*;
#(
  parameter int WIDTH     = 28,
  parameter int HEIGHT    = 28,
  parameter int DATA_BITS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  conv1_sched_if.slave  io
);
  localparam int NUM_WIN  = (WIDTH - FILTER_SIZE + 1) * (HEIGHT - FILTER_SIZE + 1);
  localparam int CNT_BITS = $clog2(NUM_WIN);

  state_e                                    state_q, state_d;
  logic [1:0]                                ch_q;
  logic [CNT_BITS-1:0]                       win_cnt_q;
  logic [TAPS-1:0][DATA_BITS-1:0]            win_q;
  logic [CHANNEL_LEN-1:0][TAPS-1:0][DATA_BITS-1:0] wgt_q;
  logic [CHANNEL_LEN-1:0][DATA_BITS-1:0]     bias_q;
  logic [TAPS-1:0][DATA_BITS-1:0]            wgt_sel;
  logic [DATA_BITS-1:0]                      bias_sel;
  logic [OUT_BITS-1:0]                       dot_res;
  out_beat_t                                 beat_q;
  logic                                      frame_done_q;
  logic                                      in_ready, out_valid, cfg_busy;
  logic                                      accept, beat_done, win_done, cfg_wr;

  assign accept    = io.in_valid && in_ready;
  assign beat_done = out_valid && io.out_ready;
  assign win_done  = beat_done && (ch_q == 2'd2);
  assign cfg_wr    = io.cfg_we && !cfg_busy && (io.cfg_addr <= CFG_ADDR_BITS'(CFG_ADDR_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (io.in_valid) state_d = CALC;
      CALC:    state_d = OUT;
      OUT:     if (io.out_ready) state_d = ((ch_q != 2'd2) || io.in_valid) ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Back-to-back acceptance only on the final beat, so a window never overlaps the previous one.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cfg_busy  = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        cfg_busy = 1'b0;
      end
      OUT: begin
        out_valid = 1'b1;
        in_ready  = io.out_ready && (ch_q == 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q         <= '0;
      win_q        <= '0;
      beat_q       <= '0;
      win_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (accept) begin
        win_q <= io.win_data;
        ch_q  <= '0;
      end else if (beat_done) begin
        ch_q <= (ch_q == 2'd2) ? 2'd0 : ch_q + 2'd1;
      end
      if (state_q == CALC) beat_q <= '{last: (ch_q == 2'd2), ch: ch_q, data: dot_res};
      if (win_done) begin
        if (win_cnt_q == CNT_BITS'(NUM_WIN - 1)) begin
          win_cnt_q    <= '0;
          frame_done_q <= 1'b1;
        end else begin
          win_cnt_q <= win_cnt_q + 1'b1;
        end
      end
    end
  end

  // Weight/bias bank; addresses past the bias slots fall through without a match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wgt_q  <= '0;
      bias_q <= '0;
    end else if (cfg_wr) begin
      for (int c = 0; c < CHANNEL_LEN; c++) begin
        for (int t = 0; t < TAPS; t++)
          if (io.cfg_addr == CFG_ADDR_BITS'(c * TAPS + t)) wgt_q[c][t] <= io.cfg_data;
        if (io.cfg_addr == CFG_ADDR_BITS'(CFG_BIAS_BASE + c)) bias_q[c] <= io.cfg_data;
      end
    end
  end

  always_comb begin
    wgt_sel  = wgt_q[0];
    bias_sel = bias_q[0];
    for (int c = 1; c < CHANNEL_LEN; c++) begin
      if (ch_q == 2'(c)) begin
        wgt_sel  = wgt_q[c];
        bias_sel = bias_q[c];
      end
    end
  end

  conv1_dot25 #(.DATA_BITS(DATA_BITS)) u_dot (
    .win  (win_q),
    .wgt  (wgt_sel),
    .bias (bias_sel),
    .res  (dot_res)
  );

  assign io.in_ready   = in_ready;
  assign io.out_valid  = out_valid;
  assign io.cfg_busy   = cfg_busy;
  assign io.out_data   = beat_q.data;
  assign io.out_ch     = beat_q.ch;
  assign io.out_last   = beat_q.last;
  assign io.frame_done = frame_done_q;
endmodule

// File: tb/tb_conv1_sched.sv
// Randomized bench for conv1_sched against an arithmetic reference model and scoreboard.
module tb_conv1_sched;
  import conv1_pkg::*;
  localparam int DB   = 8;
  localparam int WB   = TAPS * DB;
  localparam int NWIN = 24 * 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv1_sched_if #(.DATA_BITS(DB)) io ();
  conv1_sched #(.WIDTH(28), .HEIGHT(28), .DATA_BITS(DB)) dut (.clk(clk), .rst_n(rst_n), .io(io));

  int n_chk = 0, n_err = 0, cyc = 0;
  int mw[CHANNEL_LEN][TAPS];
  int mb[CHANNEL_LEN];
  logic [14:0] exp_q[$];
  logic [14:0] obs_q[$];
  int obs_cyc_q[$];
  int acc_cyc_q[$];
  int n_done = 0, fd_cnt = 0, last_done_cyc = 0;
  bit rnd_ready = 1'b0;
  logic [14:0] e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sx8(input int d);
    return (d > 127) ? d - 256 : d;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < CHANNEL_LEN; c++) begin
      mb[c] = 0;
      for (int t = 0; t < TAPS; t++) mw[c][t] = 0;
    end
  endfunction

  function automatic void model_wr(input int a, input int d);
    if (a < CFG_BIAS_BASE) mw[a / TAPS][a % TAPS] = sx8(d);
    else if (a <= CFG_ADDR_MAX) mb[a - CFG_BIAS_BASE] = sx8(d);
  endfunction

  // Plain integer dot product; bits [19:8] of the sum plus bias, modulo 4096.
  function automatic logic [11:0] ref_dot(input int c, input logic [WB-1:0] w);
    int sum = 0;
    for (int t = 0; t < TAPS; t++) sum += int'(w[8*t +: 8]) * mw[c][t];
    return 12'((sum >>> 8) + mb[c]);
  endfunction

  function automatic logic [WB-1:0] fill(input logic [7:0] v);
    logic [WB-1:0] w;
    for (int t = 0; t < TAPS; t++) w[8*t +: 8] = v;
    return w;
  endfunction

  function automatic logic [WB-1:0] rnd_win();
    logic [WB-1:0] w;
    for (int t = 0; t < TAPS; t++) w[8*t +: 8] = 8'($urandom);
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (io.out_valid && io.out_ready) begin
        obs_q.push_back({io.out_last, io.out_ch, io.out_data});
        obs_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) check("spurious_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("beat", {io.out_last, io.out_ch, io.out_data}, e);
        end
        if (io.out_last) begin
          n_done++;
          last_done_cyc = cyc;
        end
      end
      if (io.frame_done) begin
        fd_cnt++;
        check("fd_window", n_done, NWIN * fd_cnt);
        check("fd_timing", cyc - last_done_cyc, 1);
      end
      if (io.in_valid && io.in_ready) begin
        for (int c = 0; c < CHANNEL_LEN; c++)
          exp_q.push_back({(c == 2), 2'(c), ref_dot(c, io.win_data)});
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rnd_ready) io.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic cfg_wr(input int a, input int d);
    io.cfg_we = 1'b1; io.cfg_addr = 7'(a); io.cfg_data = 8'(d);
    model_wr(a, d);
    tick();
    io.cfg_we = 1'b0;
  endtask

  task automatic send_win(input logic [WB-1:0] w, input bit keep);
    int g = 0;
    io.in_valid = 1'b1; io.win_data = w;
    @(negedge clk);
    while (!io.in_ready && g < 100) begin tick(); @(negedge clk); g++; end
    if (!io.in_ready) check("accept_timeout", 0, 1);
    tick();
    if (!keep) io.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 300) begin tick(); g++; end
    check("drain", exp_q.size(), 0);
    tick(); tick();
  endtask

  task automatic wait_valid(input int ch);
    int g = 0;
    @(negedge clk);
    while (!(io.out_valid && io.out_ch == 2'(ch)) && g < 50) begin @(negedge clk); g++; end
    check("wait_valid", io.out_valid && io.out_ch == 2'(ch), 1);
  endtask

  task automatic check3(input string tag, input logic [11:0] d0, d1, d2);
    if (obs_q.size() == 3) begin
      check({tag, "_ch0"}, obs_q[0], {1'b0, 2'd0, d0});
      check({tag, "_ch1"}, obs_q[1], {1'b0, 2'd1, d1});
      check({tag, "_ch2"}, obs_q[2], {1'b1, 2'd2, d2});
    end else check({tag, "_nbeats"}, obs_q.size(), 3);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int viol;
    io.in_valid = 1'b0; io.win_data = '0; io.out_ready = 1'b1;
    io.cfg_we = 1'b0; io.cfg_addr = '0; io.cfg_data = '0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", io.out_valid, 0);
    check("rst_out_data", io.out_data, 0);
    check("rst_out_ch", io.out_ch, 0);
    check("rst_out_last", io.out_last, 0);
    check("rst_frame_done", io.frame_done, 0);
    check("rst_cfg_busy", io.cfg_busy, 0);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("rst_in_ready", io.in_ready, 1);
    tick();

    // ch0 weights all +1, full-scale pixels; latency T+2/T+4/T+6
    for (int t = 0; t < TAPS; t++) cfg_wr(t, 8'h01);
    obs_q.delete(); obs_cyc_q.delete(); acc_cyc_q.delete();
    send_win(fill(8'hFF), 0);
    wait_drain();
    check3("t1", 12'h018, 12'h000, 12'h000);
    if (obs_cyc_q.size() == 3 && acc_cyc_q.size() == 1) begin
      check("lat_ch0", obs_cyc_q[0] - acc_cyc_q[0], 2);
      check("lat_ch1", obs_cyc_q[1] - acc_cyc_q[0], 4);
      check("lat_ch2", obs_cyc_q[2] - acc_cyc_q[0], 6);
    end else check("lat_samples", obs_cyc_q.size(), 3);

    // ch1 all -1, ch2 bias 5
    for (int t = 0; t < TAPS; t++) cfg_wr(TAPS + t, 8'hFF);
    cfg_wr(77, 8'h05);
    obs_q.delete();
    send_win(fill(8'hFF), 0);
    wait_drain();
    check3("t2", 12'h018, 12'hFE7, 12'h005);

    // Backpressure on ch1 with an ignored config write while busy
    io.out_ready = 1'b0;
    send_win(rnd_win(), 0);
    wait_valid(0);
    @(posedge clk); #1; io.out_ready = 1'b1;
    @(posedge clk); #1; io.out_ready = 1'b0;
    wait_valid(1);
    @(posedge clk); #1;
    io.cfg_we = 1'b1; io.cfg_addr = 7'd0; io.cfg_data = 8'h7F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_valid", io.out_valid, 1);
      check("hold_ch", io.out_ch, 1);
      check("hold_data", io.out_data, exp_q[0][11:0]);
      check("hold_in_ready", io.in_ready, 0);
      check("hold_busy", io.cfg_busy, 1);
      @(posedge clk); #1; io.cfg_we = 1'b0;
    end
    io.out_ready = 1'b1;
    wait_drain();

    // IDLE write lands, out-of-range write is dropped
    cfg_wr(0, 8'h02);
    cfg_wr(100, 8'h55);
    obs_q.delete();
    send_win(fill(8'hFF), 0);
    wait_drain();
    check3("t4", 12'h019, 12'hFE7, 12'h005);

    // Write coinciding with acceptance is used by that window
    io.cfg_we = 1'b1; io.cfg_addr = 7'd50; io.cfg_data = 8'h40;
    model_wr(50, 8'h40);
    obs_q.delete();
    send_win(fill(8'hFF), 0);
    io.cfg_we = 1'b0;
    wait_drain();
    check3("t5", 12'h019, 12'hFE7, 12'h044);

    // Random weights, windows, gaps and backpressure
    for (int a = 0; a <= CFG_ADDR_MAX; a++) cfg_wr(a, int'($urandom_range(0, 255)));
    rnd_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (n % 10 == 9) begin
        wait_drain();
        cfg_wr(int'($urandom_range(0, 127)), int'($urandom_range(0, 255)));
      end
      send_win(rnd_win(), 0);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_drain();
    rnd_ready = 1'b0;
    io.out_ready = 1'b1;

    // Reset during CALC of ch1
    send_win(rnd_win(), 0);
    wait_valid(0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", io.out_valid, 0);
    check("midrst_out_data", io.out_data, 0);
    check("midrst_out_last", io.out_last, 0);
    exp_q.delete(); model_clear();
    n_done = 0; fd_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    tick();
    obs_q.delete();
    send_win(fill(8'hFF), 0);
    wait_drain();
    check3("t6", 12'h000, 12'h000, 12'h000);

    // Two full frames back-to-back
    for (int a = 0; a <= CFG_ADDR_MAX; a++) cfg_wr(a, int'($urandom_range(0, 255)));
    acc_cyc_q.delete();
    for (int n = 0; n < 2 * NWIN; n++) send_win(rnd_win(), 1);
    io.in_valid = 1'b0;
    wait_drain();
    viol = 0;
    for (int i = 1; i < acc_cyc_q.size(); i++)
      if (acc_cyc_q[i] - acc_cyc_q[i-1] != 6) viol++;
    check("stream_rate", viol, 0);
    check("stream_count", acc_cyc_q.size(), 2 * NWIN);
    check("fd_count", fd_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
